// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: opcode and FSM state types shared by the universal shift register.
package shift_reg_pkg;
  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_SRA  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5
  } op_e;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/shift_reg_step.sv
// shift_reg_step: combinational single-bit shift/rotate; rotates exist only with SHIFT_REG_ROTATE_EN.
module shift_reg_step import shift_reg_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] q_o,
  output logic             out_o
);
  always_comb begin
    q_o = q_i;
    out_o = 1'b0;
    case (op_i)
      OP_SHL: begin q_o = {q_i[WIDTH-2:0], serial_i}; out_o = q_i[WIDTH-1]; end
      OP_SHR: begin q_o = {serial_i, q_i[WIDTH-1:1]}; out_o = q_i[0]; end
      OP_SRA: begin q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]}; out_o = q_i[0]; end
`ifdef SHIFT_REG_ROTATE_EN
      OP_ROL: begin q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]}; out_o = q_i[WIDTH-1]; end
      OP_ROR: begin q_o = {q_i[0], q_i[WIDTH-1:1]}; out_o = q_i[0]; end
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: command-driven universal shift register (load, shifts, rotates);
// ROL/ROR are legal only when SHIFT_REG_ROTATE_EN is defined.
module shift_reg_univ import shift_reg_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] d_in,
  input  logic             serial_in,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);
`ifdef SHIFT_REG_ROTATE_EN
  localparam op_e LAST_OP = OP_ROR;
`else
  localparam op_e LAST_OP = OP_SRA;
`endif
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, step_q;
  logic so_q, so_d, done_q, done_d, err_q, err_d, step_out, legal;
  shift_reg_step #(.WIDTH(WIDTH)) u_step (
    .op_i(op_q), .q_i(q_q), .serial_i(serial_in), .q_o(step_q), .out_o(step_out)
  );
  assign cmd_ready = state_q == ST_IDLE && !reset;
  assign legal = cmd_op != OP_LOAD && cmd_op <= LAST_OP;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    q_d = q_q;
    so_d = so_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (cmd_valid && cmd_ready) begin
        if (cmd_op == OP_LOAD) begin
          q_d = d_in;
          done_d = 1'b1;
        end else if (!legal) begin
          done_d = 1'b1;
          err_d = 1'b1;
        end else if (cmd_count == '0) begin
          done_d = 1'b1;
        end else begin
          op_d = op_e'(cmd_op);
          cnt_d = cmd_count;
          state_d = ST_SHIFT;
        end
      end
    end else if (flush) begin
      // abort leaves q and serial_out as they were after the last completed step
      state_d = ST_IDLE;
      cnt_d = '0;
    end else begin
      q_d = step_q;
      so_d = step_out;
      cnt_d = cnt_q - CNT_W'(1);
      state_d = cnt_q == CNT_W'(1) ? ST_IDLE : ST_SHIFT;
      done_d = cnt_q == CNT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q <= OP_LOAD;
      cnt_q <= '0;
      q_q <= '0;
      so_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      so_q <= so_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign q = q_q;
  assign serial_out = so_q;
  assign busy = state_q == ST_SHIFT;
  assign done = done_q;
  assign cmd_err = err_q;
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: randomized scoreboard bench for shift_reg_univ (WIDTH=8) against an arithmetic model.
module tb_shift_reg_univ;
`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, cmd_valid, cmd_ready, serial_in, flush, serial_out, busy, done, cmd_err;
  logic [2:0] cmd_op;
  logic [3:0] cmd_count;
  logic [7:0] d_in, q;
  typedef struct {
    logic [7:0] q;
    logic       so;
    logic       err;
    int         due;
  } exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0, cyc = 0, m_q = 0, m_so = 0;

  shift_reg_univ #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .d_in(d_in), .serial_in(serial_in),
    .flush(flush), .q(q), .serial_out(serial_out), .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL done_pulse: got unexpected done at cycle %0d, want none", cyc);
      end else begin
        e = sb.pop_front();
        if ({q, serial_out, cmd_err, busy, cmd_ready} !== {e.q, e.so, e.err, 2'b01} || cyc != e.due) begin
          mismatched++;
          $display("FAIL result: got q=%h so=%b err=%b busy=%b ready=%b cyc=%0d, want q=%h so=%b err=%b busy=0 ready=1 cyc=%0d",
                   q, serial_out, cmd_err, busy, cmd_ready, cyc, e.q, e.so, e.err, e.due);
        end
      end
    end else if (cmd_err) begin
      compared++;
      mismatched++;
      $display("FAIL err_pulse: got cmd_err=1 without done at cycle %0d, want 0", cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void mstep(input int op, input int si);
    case (op)
      1: begin m_so = (m_q >> 7) & 1; m_q = ((m_q << 1) | si) & 255; end
      2: begin m_so = m_q & 1; m_q = (m_q >> 1) | (si << 7); end
      3: begin m_so = m_q & 1; m_q = (m_q >> 1) | (m_q & 128); end
      4: begin m_so = (m_q >> 7) & 1; m_q = ((m_q << 1) | (m_q >> 7)) & 255; end
      5: begin m_so = m_q & 1; m_q = (m_q >> 1) | ((m_q & 1) << 7); end
      default: ;
    endcase
  endfunction

  task automatic issue(input int op, input int cnt, input int data, input logic [15:0] si,
                       input int fa_req, input int ra_req, input bit fl_idle);
    int c, steps, fa, ra, run, last;
    bit legal, err;
    int sq[17];
    int sso[17];
    exp_t e;
    legal = op inside {1, 2, 3} || (ROT && op inside {4, 5});
    err = op != 0 && !legal;
    steps = legal ? cnt : 0;
    fa = fa_req > steps ? steps : fa_req;
    ra = fa > 0 ? 0 : (ra_req > steps ? steps : ra_req);
    @(negedge clk);
    for (int t = 0; t < 50 && !cmd_ready; t++) @(negedge clk);
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    c = cyc;
    cmd_valid = 1'b1;
    cmd_op = 3'(op);
    cmd_count = 4'(cnt);
    d_in = 8'(data);
    flush = fl_idle;
    serial_in = 1'($urandom);
    if (op == 0) m_q = data & 255;
    sq[0] = m_q;
    sso[0] = m_so;
    run = fa > 0 ? fa - 1 : ra > 0 ? ra - 1 : steps;
    last = fa > 0 ? fa : ra > 0 ? ra : steps;
    for (int i = 1; i <= run; i++) begin
      mstep(op, int'(si[i-1]));
      sq[i] = m_q;
      sso[i] = m_so;
    end
    if (fa == 0 && ra == 0) begin
      e.q = 8'(m_q);
      e.so = m_so[0];
      e.err = err;
      e.due = c + 1 + steps;
      sb.push_back(e);
    end
    @(posedge clk);
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      chk("busy_ready", 32'({busy, cmd_ready}), 32'd2);
      if (i > 1) chk("step_q_so", 32'({q, serial_out}), 32'({sq[i-1][7:0], sso[i-1][0]}));
      cmd_valid = 1'b0;
      if (i == ra) begin
        #1 reset = 1'b1;
        #1 chk("async_rst", 32'({q, serial_out, busy, done, cmd_err, cmd_ready}), 32'd0);
        m_q = 0;
        m_so = 0;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("ready_after_rst", 32'(cmd_ready), 32'd1);
        return;
      end
      serial_in = si[i-1];
      flush = i == fa;
      @(posedge clk);
    end
    if (fa > 0) begin
      @(negedge clk);
      flush = 1'b0;
      chk("flush_hold", 32'({q, serial_out, busy, cmd_ready}), 32'({sq[fa-1][7:0], sso[fa-1][0], 2'b01}));
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_count = '0;
    d_in = '0;
    serial_in = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({q, serial_out, busy, done, cmd_err, cmd_ready}), 32'd0);
    reset = 1'b0;
    #1 chk("ready_post_reset", 32'(cmd_ready), 32'd1);
    issue(0, 0, 'hA5, 16'h0, 0, 0, 1'b0);
    issue(2, 3, 0, 16'h0, 0, 0, 1'b0);
    issue(0, 0, 'h96, 16'h0, 0, 0, 1'b0);
    issue(3, 2, 0, 16'hFFFF, 0, 0, 1'b0);
    issue(0, 0, 'h81, 16'h0, 0, 0, 1'b0);
    issue(4, 1, 0, 16'h0, 0, 0, 1'b0);
    issue(0, 0, 'hFF, 16'h0, 0, 0, 1'b0);
    issue(1, 5, 0, 16'h0, 3, 0, 1'b0);
    issue(2, 0, 0, 16'hFFFF, 0, 0, 1'b0);
    issue(6, 3, 0, 16'h0, 0, 0, 1'b0);
    issue(7, 0, 0, 16'h0, 0, 0, 1'b0);
    issue(0, 0, 'h5A, 16'h0, 0, 0, 1'b1);
    issue(5, 12, 0, 16'hA5C3, 0, 0, 1'b1);
    issue(2, 12, 0, 16'h3C96, 0, 0, 1'b0);
    issue(1, 15, 0, 16'h1234, 0, 0, 1'b0);
    issue(0, 0, 'h3C, 16'h0, 0, 0, 1'b0);
    issue(1, 6, 0, 16'hFFFF, 0, 3, 1'b0);
    repeat (80)
      issue(int'($urandom_range(7)), int'($urandom_range(15)), int'($urandom_range(255)), 16'($urandom),
            ($urandom_range(4) == 0) ? int'($urandom_range(15, 1)) : 0, 0, 1'($urandom));
    @(negedge clk);
    cmd_valid = 1'b0;
    flush = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2 and above.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of the shift-count field.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port cmd_valid, input, 1, command present.
REQ-006 Port cmd_ready, output, 1, block can accept a command.
REQ-007 Port cmd_op, input, 3, opcode: 000 LOAD, 001 SHL, 010 SHR, 011 SRA, 100 ROL, 101 ROR, 110/111 illegal.
REQ-008 Port cmd_count, input, CNT_W, number of single-bit shift steps.
REQ-009 Port d_in, input, WIDTH, parallel load data.
REQ-010 Port serial_in, input, 1, fill bit for SHL/SHR, sampled on every shift edge.
REQ-011 Port flush, input, 1, synchronous abort of an in-progress shift.
REQ-012 Port q, output, WIDTH, register contents.
REQ-013 Port serial_out, output, 1, bit expelled or rotated by the most recent shift step.
REQ-014 Port busy, output, 1, high while in SHIFT state.
REQ-015 Port done, output, 1, one-cycle completion pulse.
REQ-016 Port cmd_err, output, 1, one-cycle pulse coincident with done for illegal/unsupported op.

Function
REQ-017 States SHALL be IDLE and SHIFT; cmd_ready = (state==IDLE) and not in reset; busy = (state==SHIFT).
REQ-018 Accept SHALL occur on an edge with cmd_valid && cmd_ready; op and count latched there.
REQ-019 LOAD: q <= d_in at accept edge; done high the following cycle; state stays IDLE.
REQ-020 Shift op with count 0: q unchanged, done next cycle, busy never asserted.
REQ-021 Shift op with count N>0: state SHIFT, exactly one step per edge on the N edges after accept; busy high N cycles; done high in the cycle after the Nth step, with state IDLE and cmd_ready high (back-to-back accept allowed).
REQ-022 Step rules: SHL q<={q[W-2:0],serial_in}, out q[W-1]; SHR q<={serial_in,q[W-1:1]}, out q[0]; SRA fill q[W-1], out q[0]; ROL/ROR rotate by one, out the wrapped bit.
REQ-023 Counts >= WIDTH SHALL execute the full count, no saturation or error.
REQ-024 flush high on a SHIFT-state edge: no step that edge, state -> IDLE, q holds, done and cmd_err stay low.
REQ-025 flush in IDLE SHALL be ignored; a simultaneous valid command is accepted normally.
REQ-026 Illegal op: accepted, q unchanged, done and cmd_err pulse next cycle.
REQ-027 serial_out SHALL hold its value between steps; LOAD does not change it.

Reset
REQ-028 While reset is high: q=0, serial_out=0, state IDLE, busy=0, done=0, cmd_err=0, cmd_ready=0, step counter=0.
REQ-029 Reset mid-SHIFT SHALL abandon the command immediately with no done pulse; cmd_ready=1 in first cycle after release.

Configuration
REQ-030 Macro SHIFT_REG_ROTATE_EN defined: ROL/ROR execute per REQ-022.
REQ-031 Macro undefined: ROL/ROR are treated as illegal per REQ-026; no rotate logic synthesised.

Structure
REQ-032 Package shift_reg_pkg SHALL hold the opcode enum typedef and state enum typedef.
REQ-033 Sub-module shift_reg_step SHALL be the combinational one-step shifter (op, q, serial_in -> next q, out bit), instanced once.

Verification (WIDTH=8)
REQ-034 Reset then LOAD d_in=8'hA5 -> q=8'hA5 one cycle after accept, done pulse 1 cycle, busy never high.
REQ-035 q=8'hA5, SHR count 3, serial_in=0 -> q 8'h52, 8'h29, 8'h14 on successive edges, serial_out 1,0,1, cmd_ready low 3 cycles, then done.
REQ-036 q=8'h96, SRA count 2 -> q 8'hCB then 8'hE5, serial_out 0 then 1, done after 2nd step.
REQ-037 q=8'h81, ROL count 1 -> with macro q=8'h03, serial_out 1; without macro q=8'h81, done and cmd_err pulse together.
REQ-038 q=8'hFF, SHL count 5, serial_in=0, flush on 3rd shift edge -> q=8'hFC, IDLE next cycle, no done.
REQ-039 Async reset asserted mid-SHIFT between edges -> q=8'h00 and busy=0 without waiting for clk.
